summer_uart_tx: RTL and testbench

Buffered UART transmitter that serialises bytes from the core datapath of `tt_um_SummerTT_HDL` onto one dedicated output pin (8N1, LSB first). It sits directly upstream of the top-level `uo_out` bus. The core pushes bytes through a valid/ready handshake into a small FIFO, and the block drains them as back-to-back frames.

---
 rtl/summer_uart_tx.sv | 134 +++++++++++++
 tb/tb_summer_uart_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/summer_uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO with a valid/ready push side,
// drained LSB-first onto a single registered serial pin.
module summer_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          baud_last;

    // Ready depends only on the registered count, so a full FIFO refuses a push
    // even on the cycle the FSM pops.
    assign in_ready  = (fifo_count < DEPTH);
    assign push      = in_valid && in_ready;
    assign pop       = (state == ST_IDLE) && (fifo_count != '0);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // tx is updated on the same edge as each state change, so every bit lasts
    // exactly CLKS_PER_BIT cycles and IDLE between frames lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        shift    <= shift >> 1;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_summer_uart_tx.sv
// Directed bench for summer_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a serial
// receiver decodes tx and each test task compares against hand-computed values.
module tb_summer_uart_tx;
    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       stop_q[$];
    logic [7:0] mon_byte;
    int         mon_start;

    summer_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: first low sample marks the start bit, data sampled mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                mon_start = cyc;
                mon_byte  = 8'h00;
                repeat (6) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    mon_byte[i] = tx;
                    if (i < 7) repeat (4) @(negedge clk);
                end
                repeat (4) @(negedge clk);
                rx_q.push_back(mon_byte);
                start_q.push_back(mon_start);
                stop_q.push_back(tx);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        start_q.delete();
        stop_q.delete();
    endtask

    // Holds in_valid high until the byte is taken; acc is the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int acc);
        logic rdy;
        bit   ok;
        ok      = 1'b0;
        acc     = -1;
        in_data = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok  = 1'b1;
                acc = cyc;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL push_timeout byte=%02h never accepted", b);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int i;
        i = 0;
        while (rx_q.size() < n && i < budget) begin
            @(posedge clk);
            i++;
        end
        total++;
        if (rx_q.size() < n) begin
            bad++;
            $display("[TB] FAIL rx_timeout got=%0d frames want=%0d", rx_q.size(), n);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", in_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_single();
        int         n;
        logic       exp_tx;
        logic [7:0] pat;
        align();
        clear_rx();
        pat = 8'hA5;
        push_byte(pat, n);
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL single_count_after_push got=%0d want=1", fifo_count); end
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k <= 4)       exp_tx = 1'b0;
            else if (k <= 36) exp_tx = pat[(k - 5) / 4];
            else              exp_tx = 1'b1;
            total++;
            if (tx !== exp_tx) begin
                bad++;
                $display("[TB] FAIL single_wave cycle=N+%0d got=%b want=%b", k, tx, exp_tx);
            end
            if (k == 1) begin
                total++;
                if (fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL single_count_after_pop got=%0d want=0", fifo_count); end
            end
            if (k == 40) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_stop got=%b want=1", busy); end
            end
            if (k == 41) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_end got=%b want=0", busy); end
            end
        end
    endtask

    task automatic test_fill();
        int         n0;
        int         acc;
        logic [7:0] exp_b;
        align();
        clear_rx();
        push_byte(8'h01, n0);
        push_byte(8'h02, acc);
        push_byte(8'h03, acc);
        push_byte(8'h04, acc);
        push_byte(8'h05, acc);
        total++;
        if (acc != n0 + 4) begin bad++; $display("[TB] FAIL fill_fifth_edge got=%0d want=%0d", acc - n0, 4); end
        total++;
        if (fifo_count !== 3'd4) begin bad++; $display("[TB] FAIL fill_count_full got=%0d want=4", fifo_count); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_ready_full got=%b want=0", in_ready); end
        push_byte(8'h06, acc);
        in_valid = 1'b0;
        total++;
        if (acc != n0 + 43) begin bad++; $display("[TB] FAIL fill_sixth_edge got=N+%0d want=N+43", acc - n0); end
        wait_rx(6, 400);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            exp_b = 8'(i + 1);
            total++;
            if (rx_q[i] !== exp_b) begin bad++; $display("[TB] FAIL fill_data idx=%0d got=%02h want=%02h", i, rx_q[i], exp_b); end
            total++;
            if (start_q[i] != n0 + 1 + 41 * i) begin
                bad++;
                $display("[TB] FAIL fill_start idx=%0d got=N+%0d want=N+%0d", i, start_q[i] - n0, 1 + 41 * i);
            end
            total++;
            if (stop_q[i] !== 1'b1) begin bad++; $display("[TB] FAIL fill_stop idx=%0d got=%b want=1", i, stop_q[i]); end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL fill_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        int         a;
        int         s;
        int         guard;
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h5A;
        exp_seq[1] = 8'hC3;
        exp_seq[2] = 8'h3C;
        align();
        clear_rx();
        push_byte(8'h5A, a);
        s = a + 1;
        push_byte(8'hC3, a);
        in_valid = 1'b0;
        total++;
        if (fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL simul_first_count got=%0d want=1", fifo_count); end
        guard = 0;
        while (cyc < s + 40 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL simul_count_idle got=%0d want=1", fifo_count); end
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL simul_count_pushpop got=%0d want=1", fifo_count); end
        @(negedge clk);
        total++;
        if (tx !== 1'b0) begin bad++; $display("[TB] FAIL simul_second_start got=%b want=0", tx); end
        wait_rx(3, 200);
        total++;
        if (rx_q.size() != 3) begin bad++; $display("[TB] FAIL simul_frame_count got=%0d want=3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_seq[i]) begin bad++; $display("[TB] FAIL simul_data idx=%0d got=%02h want=%02h", i, rx_q[i], exp_seq[i]); end
        end
    endtask

    task automatic test_wrap();
        int         acc;
        logic [7:0] exp_b;
        align();
        clear_rx();
        for (int i = 0; i < 12; i++) begin
            push_byte(8'(8'h10 + i), acc);
        end
        in_valid = 1'b0;
        wait_rx(12, 700);
        for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
            exp_b = 8'(8'h10 + i);
            total++;
            if (rx_q[i] !== exp_b) begin bad++; $display("[TB] FAIL wrap_data idx=%0d got=%02h want=%02h", i, rx_q[i], exp_b); end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wrap_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        int a;
        int guard;
        int lows;
        align();
        clear_rx();
        push_byte(8'hFF, n);
        push_byte(8'h11, a);
        push_byte(8'h22, a);
        in_valid = 1'b0;
        guard = 0;
        while (cyc < n + 17 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (fifo_count !== 3'd2) begin bad++; $display("[TB] FAIL rstmid_count_before got=%0d want=2", fifo_count); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_tx got=%b want=1", tx); end
        total++;
        if (fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=0", fifo_count); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
        lows = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin bad++; $display("[TB] FAIL rstmid_no_frames got=%0d low cycles want=0", lows); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        $display("[TB] starting summer_uart_tx bench");
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
